execute_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the `execute` stage (ALU operand select, ALU operation, zero flag) for one LEGv8 instruction at a time.
- Accepts an opcode through a valid/ready handshake, then walks DECODE → EXEC → MEM → WB.
- Drives AluSrc/AluControl into `execute` and emits one-cycle strobes for the register file, data memory and PC.
- Sits between instruction fetch and the datapath in the multi-cycle variant of the processor.

---
 rtl/execute_sequencer.sv | 142 ++++++++++++++
 tb/tb_execute_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_sequencer.sv
// Multi-cycle LEGv8 control FSM: accepts one opcode, then walks DECODE/EXEC/MEM/WB driving execute-stage controls.
// Latency: done at accept+1 (illegal), +2 (CBZ), +3 (R-type, STUR), +4 (LDUR); ready only in IDLE, no back-to-back accepts.
module execute_sequencer #(
    parameter int OP_W   = 11,
    parameter int ALUC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic              zero_E,
    output logic              AluSrc,
    output logic [ALUC_W-1:0] AluControl,
    output logic              irWrite,
    output logic              regWrite,
    output logic              memtoReg,
    output logic              memRead,
    output logic              memWrite,
    output logic              pcWrite,
    output logic              pcSrc,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_ILL} cls_t;

    state_t            state;
    state_t            state_nxt;
    logic [OP_W-1:0]   op_q;
    cls_t              cls;
    logic [ALUC_W-1:0] alu_op;
    logic              alu_imm;
    logic              accept;

    assign accept = instr_valid && (state == S_IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= opcode;
            end
        end
    end

    // Class and ALU controls come from the latched opcode only, so later opcode changes are ignored.
    always_comb begin
        cls     = C_ILL;
        alu_op  = 4'b0010;
        alu_imm = 1'b0;
        casez (op_q)
            11'b10001011000: begin cls = C_RTYPE; alu_op = 4'b0010; end
            11'b11001011000: begin cls = C_RTYPE; alu_op = 4'b0110; end
            11'b10001010000: begin cls = C_RTYPE; alu_op = 4'b0000; end
            11'b10101010000: begin cls = C_RTYPE; alu_op = 4'b0001; end
            11'b11111000010: begin cls = C_LDUR;  alu_op = 4'b0010; alu_imm = 1'b1; end
            11'b11111000000: begin cls = C_STUR;  alu_op = 4'b0010; alu_imm = 1'b1; end
            11'b10110100???: begin cls = C_CBZ;   alu_op = 4'b0111; end
            default:         begin cls = C_ILL; end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (cls == C_ILL) ? S_IDLE : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_RTYPE:        state_nxt = S_WB;
                    C_LDUR, C_STUR: state_nxt = S_MEM;
                    default:        state_nxt = S_IDLE;
                endcase
            end
            S_MEM:    state_nxt = (cls == C_LDUR) ? S_WB : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted so an aborted instruction never strobes.
    always_comb begin
        instr_ready = 1'b0;
        AluSrc      = 1'b0;
        AluControl  = 4'b0010;
        irWrite     = 1'b0;
        regWrite    = 1'b0;
        memtoReg    = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        pcWrite     = 1'b0;
        pcSrc       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            if (state == S_EXEC || state == S_MEM || state == S_WB) begin
                AluSrc     = alu_imm;
                AluControl = alu_op;
            end
            case (state)
                S_IDLE: begin
                    instr_ready = 1'b1;
                    irWrite     = instr_valid;
                end
                S_DECODE: begin
                    if (cls == C_ILL) begin
                        illegal = 1'b1;
                        done    = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cls == C_CBZ) begin
                        pcWrite = 1'b1;
                        pcSrc   = zero_E;
                        done    = 1'b1;
                    end
                end
                S_MEM: begin
                    if (cls == C_LDUR) begin
                        memRead = 1'b1;
                    end else begin
                        memWrite = 1'b1;
                        pcWrite  = 1'b1;
                        done     = 1'b1;
                    end
                end
                S_WB: begin
                    regWrite = 1'b1;
                    memtoReg = (cls == C_LDUR);
                    pcWrite  = 1'b1;
                    done     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_sequencer.sv
// Directed bench for execute_sequencer: per-cycle expected output vectors for each instruction class.
module tb_execute_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [10:0] opcode;
    logic        zero_E;
    logic        AluSrc;
    logic [3:0]  AluControl;
    logic        irWrite, regWrite, memtoReg, memRead, memWrite, pcWrite, pcSrc, done, illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    // Strobe order: irWrite regWrite memtoReg memRead memWrite pcWrite pcSrc done illegal
    localparam logic [8:0] S_NONE = 9'b000000000;
    localparam logic [8:0] S_IR   = 9'b100000000;

    execute_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .zero_E     (zero_E),
        .AluSrc     (AluSrc),
        .AluControl (AluControl),
        .irWrite    (irWrite),
        .regWrite   (regWrite),
        .memtoReg   (memtoReg),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .pcWrite    (pcWrite),
        .pcSrc      (pcSrc),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {instr_ready, AluSrc, AluControl, irWrite, regWrite, memtoReg,
                memRead, memWrite, pcWrite, pcSrc, done, illegal};
    endfunction

    function automatic logic [14:0] ex(input logic rdy, input logic src,
                                       input logic [3:0] c, input logic [8:0] s);
        return {rdy, src, c, s};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] e [0:6];
        reset = 1'b1; instr_valid = 1'b0; opcode = OP_ADD; zero_E = 1'b0;
        next_cycle();
        @(negedge clk);
        total++;
        if (obs() !== ex(0, 0, 4'b0010, S_NONE)) begin
            bad++; $display("FAIL reset_hold: got %b want %b", obs(), ex(0, 0, 4'b0010, S_NONE));
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs() !== ex(1, 0, 4'b0010, S_NONE)) begin
            bad++; $display("FAIL reset_idle: got %b want %b", obs(), ex(1, 0, 4'b0010, S_NONE));
        end
        next_cycle();
        // LDUR aborted in MEM by a two-cycle reset
        e[0] = ex(1, 0, 4'b0010, S_IR);
        e[1] = ex(0, 0, 4'b0010, S_NONE);
        e[2] = ex(0, 1, 4'b0010, S_NONE);
        e[3] = ex(0, 0, 4'b0010, S_NONE);
        e[4] = ex(0, 0, 4'b0010, S_NONE);
        e[5] = ex(1, 0, 4'b0010, S_NONE);
        e[6] = ex(1, 0, 4'b0010, S_NONE);
        opcode = OP_LDUR;
        for (int k = 0; k < 7; k++) begin
            instr_valid = (k == 0);
            reset = (k == 3 || k == 4);
            @(negedge clk);
            total++;
            if (obs() !== e[k]) begin
                bad++; $display("FAIL reset_mid_ldur cycle %0d: got %b want %b", k, obs(), e[k]);
            end
            next_cycle();
        end
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [14:0] e [0:4];
        e[0] = ex(1, 0, 4'b0010, S_IR);
        e[1] = ex(0, 0, 4'b0010, S_NONE);
        e[2] = ex(0, 0, 4'b0010, S_NONE);
        e[3] = ex(0, 0, 4'b0010, 9'b010001010);
        e[4] = ex(1, 0, 4'b0010, S_NONE);
        opcode = OP_ADD; zero_E = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instr_valid = (k == 0);
            @(negedge clk);
            total++;
            if (obs() !== e[k]) begin
                bad++; $display("FAIL add cycle %0d: got %b want %b", k, obs(), e[k]);
            end
            next_cycle();
        end
        zero_E = 1'b0;
    endtask

    task automatic test_ldur();
        logic [14:0] e [0:5];
        e[0] = ex(1, 0, 4'b0010, S_IR);
        e[1] = ex(0, 0, 4'b0010, S_NONE);
        e[2] = ex(0, 1, 4'b0010, S_NONE);
        e[3] = ex(0, 1, 4'b0010, 9'b000100000);
        e[4] = ex(0, 1, 4'b0010, 9'b011001010);
        e[5] = ex(1, 0, 4'b0010, S_NONE);
        opcode = OP_LDUR;
        for (int k = 0; k < 6; k++) begin
            instr_valid = (k == 0);
            @(negedge clk);
            total++;
            if (obs() !== e[k]) begin
                bad++; $display("FAIL ldur cycle %0d: got %b want %b", k, obs(), e[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_stur();
        logic [14:0] e [0:4];
        e[0] = ex(1, 0, 4'b0010, S_IR);
        e[1] = ex(0, 0, 4'b0010, S_NONE);
        e[2] = ex(0, 1, 4'b0010, S_NONE);
        e[3] = ex(0, 1, 4'b0010, 9'b000011010);
        e[4] = ex(1, 0, 4'b0010, S_NONE);
        opcode = OP_STUR;
        for (int k = 0; k < 5; k++) begin
            instr_valid = (k == 0);
            @(negedge clk);
            total++;
            if (obs() !== e[k]) begin
                bad++; $display("FAIL stur cycle %0d: got %b want %b", k, obs(), e[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_cbz();
        logic [14:0] e [0:3];
        for (int t = 0; t < 2; t++) begin
            e[0] = ex(1, 0, 4'b0010, S_IR);
            e[1] = ex(0, 0, 4'b0010, S_NONE);
            e[2] = ex(0, 0, 4'b0111, (t == 0) ? 9'b000001110 : 9'b000001010);
            e[3] = ex(1, 0, 4'b0010, S_NONE);
            opcode = OP_CBZ;
            for (int k = 0; k < 4; k++) begin
                instr_valid = (k == 0);
                // zero_E only matters in EXEC; elsewhere drive the opposite value
                zero_E = (k == 2) ? (t == 0) : (t != 0);
                @(negedge clk);
                total++;
                if (obs() !== e[k]) begin
                    bad++; $display("FAIL cbz_%s cycle %0d: got %b want %b",
                                    (t == 0) ? "taken" : "not_taken", k, obs(), e[k]);
                end
                next_cycle();
            end
        end
        zero_E = 1'b0;
    endtask

    task automatic test_illegal();
        logic [14:0] e [0:2];
        e[0] = ex(1, 0, 4'b0010, S_IR);
        e[1] = ex(0, 0, 4'b0010, 9'b000000011);
        e[2] = ex(1, 0, 4'b0010, S_NONE);
        opcode = OP_BAD;
        for (int k = 0; k < 3; k++) begin
            instr_valid = (k == 0);
            @(negedge clk);
            total++;
            if (obs() !== e[k]) begin
                bad++; $display("FAIL illegal cycle %0d: got %b want %b", k, obs(), e[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] e [0:8];
        e[0] = ex(1, 0, 4'b0010, S_IR);
        e[1] = ex(0, 0, 4'b0010, S_NONE);
        e[2] = ex(0, 0, 4'b0110, S_NONE);
        e[3] = ex(0, 0, 4'b0110, 9'b010001010);
        e[4] = ex(1, 0, 4'b0010, S_IR);
        e[5] = ex(0, 0, 4'b0010, S_NONE);
        e[6] = ex(0, 0, 4'b0000, S_NONE);
        e[7] = ex(0, 0, 4'b0000, 9'b010001010);
        e[8] = ex(1, 0, 4'b0010, S_NONE);
        for (int k = 0; k < 9; k++) begin
            instr_valid = (k <= 4);
            opcode = (k == 0) ? OP_SUB : OP_AND;
            @(negedge clk);
            total++;
            if (obs() !== e[k]) begin
                bad++; $display("FAIL back_to_back cycle %0d: got %b want %b", k, obs(), e[k]);
            end
            next_cycle();
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; opcode = '0; zero_E = 1'b0;
        #1;
        test_reset();
        test_add();
        test_ldur();
        test_stur();
        test_cbz();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
